activation_scheduler: RTL and testbench
=======================================

# activation_scheduler

Sequencing controller for the spiking activation datapath. It accepts a run command, counts membrane-potential steps into fixed-length accumulation intervals, and pulses the accumulator clear to the activation elements. At every interval boundary it holds a sample window open until downstream takes the accumulated spike counts. It sits between the layer controller (start/abort, configuration) and the activation unit plus its output consumer.

## Interface
- TIMER_WIDTH, 5: width of the step timer and of `accumulate_interval`.
- IDX_WIDTH, 8: width of the interval counter and of `num_intervals`.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- abort  in  1  terminate the current run; ignored in IDLE.
- accumulate_interval  in  TIMER_WIDTH  steps per interval; latched when start is accepted.
- num_intervals  in  IDX_WIDTH  intervals per run; latched when start is accepted.
- step_valid  in  1  upstream presents a new membrane-potential step.
- step_ready  out  1  scheduler consumes steps (state ACCUM).
- acc_en  out  1  activation elements integrate this cycle (step_valid & step_ready).
- acc_clear  out  1  one-cycle accumulated-spike reset to the activation elements.
- timer  out  TIMER_WIDTH  steps consumed in the current interval.
- sample_valid  out  1  accumulated counts are valid for the interval `interval_idx`.
- sample_ready  in  1  downstream accepts the sample.
- interval_idx  out  IDX_WIDTH  index of the current interval, 0-based.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the run completes normally.
- cfg_err  out  1  one-cycle pulse when start is rejected because of a zero configuration.

## Operation
- The state machine has four states: IDLE, ACCUM, SAMPLE, DONE. Its state and all counters are registers.
- **IDLE**
  - If start=1 and both latched-to-be values are nonzero: latch the configuration, set timer=0 and interval_idx=0, assert acc_clear this cycle, and go to ACCUM.
  - If start=1 and either value is zero: assert cfg_err, stay in IDLE, do not assert acc_clear.
- **ACCUM**
  - step_ready=1.
  - On each cycle with step_valid=1, the timer increments.
  - On a step with timer == interval-1, the timer wraps to 0 and the state goes to SAMPLE.
  - When step_valid=0, the timer holds.
- **SAMPLE**
  - sample_valid=1 and step_ready=0. interval_idx and the counts are held stable until the handshake.
  - On sample_valid & sample_ready:
    - if interval_idx == num_intervals-1, go to DONE;
    - otherwise interval_idx increments, acc_clear is asserted in the same cycle, and the state goes to ACCUM.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
  - interval_idx holds its last value until the next start.
- **abort**
  - In ACCUM, SAMPLE or DONE: go to IDLE next cycle and assert acc_clear that cycle. done is not asserted.
  - abort has priority over a same-cycle step or sample handshake. That handshake does not complete, and acc_en is forced to 0.
- **Output equations:** acc_clear = (IDLE & start accepted) | (SAMPLE & handshake & not last) | (abort & busy).
- **Counter widths:**
  - The timer compares against the latched interval with no overflow: the maximum interval is 2^TIMER_WIDTH-1.
  - interval_idx never exceeds num_intervals-1.
- **Reset:** rst forces IDLE, with timer=0 and interval_idx=0. It takes priority over every other input, including in the middle of a run.

## Timing
- Reset values of outputs: step_ready=0, acc_en=0, acc_clear=0, timer=0, sample_valid=0, interval_idx=0, busy=0, done=0, cfg_err=0.
- Start accepted in cycle 0 leads to ACCUM from cycle 1.
- With step_valid held high and interval N, the steps are consumed in cycles 1..N and sample_valid rises in cycle N+1.
- With sample_ready held high, each interval costs N+1 cycles. done follows one cycle after the final handshake.
- A new start is accepted at the earliest in the cycle after done (the IDLE cycle).
- step_ready, acc_en, sample_valid, busy and done are decoded from the registered state. acc_en and acc_clear are combinational in the same cycle as their qualifying inputs.

## Configuration
- With `ACT_SCHED_STALL_COUNT_EN` defined:
  - the block adds the output stall_cycles (16 bits);
  - the counter increments on every cycle in SAMPLE with sample_ready=0;
  - it saturates at 0xFFFF, clears on start accept and on rst, and holds across DONE and IDLE.
- Without the macro, neither the port nor the logic exists. All other behaviour is identical.

## Structure
- Shared package activation_pkg holds:
  - the state enum (IDLE, ACCUM, SAMPLE, DONE);
  - default TIMER_WIDTH and IDX_WIDTH constants;
  - the stall-counter width constant.
- One sub-module, interval_timer, contains the enable-gated timer with its wrap compare and exposes the terminal-step flag. The FSM and the interval counter stay in activation_scheduler.

## Test plan
- **Basic run:** start with interval=4, intervals=3, step_valid=1, sample_ready=1 -> sample_valid in cycles 5, 10, 15 with interval_idx 0, 1, 2; done in cycle 16; acc_clear in cycles 0, 5, 10 only.
- **Gapped steps:** step_valid toggling 1,0,1,0 with interval=3 -> the timer holds on the gaps, acc_en pulses 3 times, and sample_valid appears after the third valid step.
- **Backpressure:** sample_ready=0 for 7 cycles -> interval_idx and sample_valid are stable, step_ready=0, and stall_cycles=7 (macro on).
- **Abort in SAMPLE with sample_ready=1 in the same cycle** -> no increment, no done, acc_clear=1, and busy=0 the next cycle.
- **Zero configuration:** start with interval=0 -> cfg_err pulse, state stays IDLE, acc_clear=0; repeat with intervals=0 and get the same response.
- **rst asserted mid-ACCUM with timer=2** -> all outputs return to reset values next cycle, and a following start runs normally.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared types and sizing constants for the spiking activation scheduler.
package activation_pkg;

  localparam int TIMER_WIDTH_DEF = 5;
  localparam int IDX_WIDTH_DEF   = 8;
  localparam int STALL_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/interval_timer.sv
// Step timer for one accumulation interval; wraps to zero on the terminal step.
module interval_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] interval,
  output logic [W-1:0] timer,
  output logic         terminal
);

  logic [W-1:0] timer_q;
  logic [W-1:0] timer_d;

  // interval is never zero while stepping, so interval-1 cannot underflow here
  assign terminal = (timer_q == (interval - W'(1)));
  assign timer    = timer_q;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (step) begin
      timer_d = terminal ? '0 : timer_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/activation_scheduler.sv
// Run sequencer: counts steps into intervals, clears accumulators, holds sample windows.
// Optional saturating sample-stall counter under ACT_SCHED_STALL_COUNT_EN.
module activation_scheduler
  import activation_pkg::*;
#(
  parameter int TIMER_WIDTH = TIMER_WIDTH_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TIMER_WIDTH-1:0] accumulate_interval,
  input  logic [IDX_WIDTH-1:0]   num_intervals,
  input  logic                   step_valid,
  output logic                   step_ready,
  output logic                   acc_en,
  output logic                   acc_clear,
  output logic [TIMER_WIDTH-1:0] timer,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [IDX_WIDTH-1:0]   interval_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output state_t                 dbg_state
`ifdef ACT_SCHED_STALL_COUNT_EN
  ,
  output logic [STALL_WIDTH-1:0] stall_cycles
`endif
);

  // Handshakes: a step transfers on step_valid & step_ready, a sample on
  // sample_valid & sample_ready; an abort in the same cycle cancels either.
  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [TIMER_WIDTH-1:0] interval_q, interval_d;
  logic [IDX_WIDTH-1:0]   num_q, num_d;

  logic start_req, cfg_ok, start_ok, abort_act;
  logic step_fire, sample_hs, last_interval, terminal, timer_clear;

  assign busy         = (state_q != ST_IDLE);
  assign step_ready   = (state_q == ST_ACCUM);
  assign sample_valid = (state_q == ST_SAMPLE);
  assign done         = (state_q == ST_DONE);
  assign dbg_state    = state_q;
  assign interval_idx = idx_q;

  assign start_req     = (state_q == ST_IDLE) & start;
  assign cfg_ok        = (|accumulate_interval) & (|num_intervals);
  assign start_ok      = start_req & cfg_ok;
  assign cfg_err       = start_req & ~cfg_ok;
  assign abort_act     = abort & busy;
  assign step_fire     = step_ready & step_valid & ~abort;
  assign sample_hs     = sample_valid & sample_ready & ~abort;
  assign last_interval = (idx_q == (num_q - IDX_WIDTH'(1)));
  assign acc_en        = step_fire;
  assign acc_clear     = start_ok | (sample_hs & ~last_interval) | abort_act;
  assign timer_clear   = start_ok | abort_act;

  interval_timer #(.W(TIMER_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .step     (step_fire),
    .interval (interval_q),
    .timer    (timer),
    .terminal (terminal)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    interval_d = interval_q;
    num_d      = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          interval_d = accumulate_interval;
          num_d      = num_intervals;
          idx_d      = '0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_fire && terminal) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sample_hs) begin
          if (last_interval) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = ST_ACCUM;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      interval_q <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      interval_q <= interval_d;
      num_q      <= num_d;
    end
  end

`ifdef ACT_SCHED_STALL_COUNT_EN
  logic [STALL_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (sample_valid && !sample_ready && !(&stall_q)) begin
      stall_d = stall_q + STALL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed plus randomized bench for activation_scheduler against a flag-level reference model.
module tb_activation_scheduler;

  localparam int TW = 5;
  localparam int IW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [TW-1:0] accumulate_interval;
  logic [IW-1:0] num_intervals;
  logic          step_valid;
  logic          step_ready;
  logic          acc_en;
  logic          acc_clear;
  logic [TW-1:0] timer;
  logic          sample_valid;
  logic          sample_ready;
  logic [IW-1:0] interval_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [1:0]    dbg_state;
`ifdef ACT_SCHED_STALL_COUNT_EN
  logic [15:0]   stall_cycles;
`endif

  activation_scheduler #(.TIMER_WIDTH(TW), .IDX_WIDTH(IW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .accumulate_interval (accumulate_interval),
    .num_intervals       (num_intervals),
    .step_valid          (step_valid),
    .step_ready          (step_ready),
    .acc_en              (acc_en),
    .acc_clear           (acc_clear),
    .timer               (timer),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
    .interval_idx        (interval_idx),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
    .dbg_state           (dbg_state)
`ifdef ACT_SCHED_STALL_COUNT_EN
    ,
    .stall_cycles        (stall_cycles)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // reference model: run/sample/done flags plus plain counters
  bit m_busy, m_sampling, m_done;
  int m_timer, m_idx, m_iv, m_ni, m_stall;

  logic [IW-1:0] exp_q[$];

  int cyc = 0;
  bit rec = 0;
  int t0  = 0;
  int sv_q[$], svi_q[$], done_q[$], clr_q[$];
  int acc_en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sampling = 0; m_done = 0;
    m_timer = 0; m_idx = 0; m_iv = 0; m_ni = 0; m_stall = 0;
  endtask

  function automatic bit m_accept();
    return !m_busy && start && (accumulate_interval != 0) && (num_intervals != 0);
  endfunction

  function automatic bit m_hs();
    return m_sampling && sample_ready && !abort;
  endfunction

  function automatic bit m_last();
    return m_idx == m_ni - 1;
  endfunction

  task automatic check_outputs();
    bit e_ready, e_clear;
    e_ready = m_busy && !m_sampling && !m_done;
    e_clear = m_accept() || (m_hs() && !m_last()) || (abort && m_busy);
    chk("step_ready", step_ready, e_ready);
    chk("acc_en", acc_en, e_ready && step_valid && !abort);
    chk("acc_clear", acc_clear, e_clear);
    chk("timer", timer, m_timer);
    chk("sample_valid", sample_valid, m_sampling);
    chk("interval_idx", interval_idx, m_idx);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("cfg_err", cfg_err, !m_busy && start && !m_accept());
`ifdef ACT_SCHED_STALL_COUNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    if (m_hs()) exp_q.push_back(IW'(m_idx));
  endtask

  task automatic model_update();
    bit acc, hs, last;
    acc  = m_accept();
    hs   = m_hs();
    last = m_last();
    if (rst) begin
      model_reset();
    end else begin
      if (m_sampling && !sample_ready && m_stall < 16'hFFFF) m_stall++;
      if (!m_busy) begin
        if (acc) begin
          m_busy = 1; m_iv = accumulate_interval; m_ni = num_intervals;
          m_timer = 0; m_idx = 0; m_stall = 0;
        end
      end else if (abort) begin
        m_busy = 0; m_sampling = 0; m_done = 0; m_timer = 0;
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (m_sampling) begin
        if (hs) begin
          m_sampling = 0;
          if (last) m_done = 1;
          else m_idx++;
        end
      end else if (step_valid) begin
        m_timer++;
        if (m_timer == m_iv) begin
          m_timer = 0;
          m_sampling = 1;
        end
      end
    end
  endtask

  // one clock: check at negedge+1, advance model at the posedge
  task automatic tick();
    #1;
    check_outputs();
    if (sample_valid && sample_ready && !abort) begin
      if (exp_q.size() == 0) chk("sb_unexpected_hs", 1, 0);
      else chk("sb_hs_idx", interval_idx, exp_q.pop_front());
    end
    if (acc_en) acc_en_cnt++;
    if (rec) begin
      if (sample_valid) begin sv_q.push_back(cyc - t0); svi_q.push_back(interval_idx); end
      if (done) done_q.push_back(cyc - t0);
      if (acc_clear) clr_q.push_back(cyc - t0);
    end
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive_idle();
    start = 0; abort = 0; step_valid = 0; sample_ready = 0; rst = 0;
  endtask

  task automatic start_run(input int iv, input int ni);
    accumulate_interval = TW'(iv);
    num_intervals = IW'(ni);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_sample(input string tag);
    int n = 0;
    while (sample_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk(tag, n < 40, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    chk(tag, n < 200, 1);
  endtask

  int exp_sv[3]  = '{5, 10, 15};
  int exp_clr[3] = '{0, 5, 10};

  initial begin
    drive_idle();
    rst = 1;
    accumulate_interval = '0;
    num_intervals = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 0;
    tick();

    // basic run: interval 4, three intervals, no stalls
    step_valid = 1; sample_ready = 1;
    rec = 1; t0 = cyc;
    start_run(4, 3);
    for (int i = 0; i < 19; i++) tick();
    rec = 0;
    chk("basic_sv_count", sv_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("basic_sv_cycle", (i < sv_q.size()) ? sv_q[i] : -1, exp_sv[i]);
      chk("basic_sv_idx", (i < svi_q.size()) ? svi_q[i] : -1, i);
      chk("basic_clr_cycle", (i < clr_q.size()) ? clr_q[i] : -1, exp_clr[i]);
    end
    chk("basic_clr_count", clr_q.size(), 3);
    chk("basic_done_count", done_q.size(), 1);
    chk("basic_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, 16);

    // gapped steps: interval 3, valid every other cycle
    drive_idle();
    sample_ready = 1;
    start_run(3, 1);
    acc_en_cnt = 0;
    for (int k = 0; k < 20 && sample_valid !== 1'b1; k++) begin
      step_valid = (k % 2 == 0);
      tick();
    end
    chk("gap_sample_seen", sample_valid, 1);
    chk("gap_acc_en_pulses", acc_en_cnt, 3);
    step_valid = 0;
    wait_idle("gap_finish");

    // backpressure: hold sample_ready low for seven SAMPLE cycles
    drive_idle();
    step_valid = 1;
    start_run(2, 2);
    wait_sample("bp_wait_sample");
    for (int i = 0; i < 7; i++) tick();
    chk("bp_idx_stable", interval_idx, 0);
    chk("bp_step_ready", step_ready, 0);
`ifdef ACT_SCHED_STALL_COUNT_EN
    chk("bp_stall7", stall_cycles, 7);
`endif
    sample_ready = 1;
    wait_idle("bp_finish");

    // abort in SAMPLE with a same-cycle handshake
    drive_idle();
    step_valid = 1;
    start_run(2, 3);
    wait_sample("ab_wait_sample");
    sample_ready = 1; abort = 1;
    #1;
    chk("ab_acc_clear", acc_clear, 1);
    tick();
    abort = 0; sample_ready = 0; step_valid = 0;
    chk("ab_busy", busy, 0);
    chk("ab_idx", interval_idx, 0);
    tick();
    chk("ab_no_done", done, 0);

    // zero configuration is rejected
    drive_idle();
    accumulate_interval = 0; num_intervals = 3; start = 1;
    #1;
    chk("zero_iv_err", cfg_err, 1);
    chk("zero_iv_clr", acc_clear, 0);
    tick();
    chk("zero_iv_idle", busy, 0);
    accumulate_interval = 4; num_intervals = 0;
    #1;
    chk("zero_ni_err", cfg_err, 1);
    chk("zero_ni_clr", acc_clear, 0);
    tick();
    start = 0;
    chk("zero_ni_idle", busy, 0);

    // reset mid-ACCUM, then a clean run
    step_valid = 1;
    start_run(5, 2);
    tick();
    tick();
    chk("rst_timer2", timer, 2);
    rst = 1;
    tick();
    rst = 0; step_valid = 0;
    chk("rst_busy", busy, 0);
    chk("rst_timer", timer, 0);
    chk("rst_ready", step_ready, 0);
    step_valid = 1; sample_ready = 1;
    start_run(2, 2);
    wait_idle("rst_rerun");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      step_valid = $urandom_range(0, 1);
      sample_ready = $urandom_range(0, 1);
      accumulate_interval = TW'($urandom_range(0, 4));
      num_intervals = IW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    drive_idle();
    tick();
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
